// File: rtl/calc_pkg.sv
//------------------------------------------------------------------------------
// calc_pkg : key codes, ALU operator and sequencer state encodings for the
//            calculator entry controller.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package calc_pkg;

  localparam logic [4:0] KEY_ADD = 5'h10;
  localparam logic [4:0] KEY_MUL = 5'h11;
  localparam logic [4:0] KEY_AND = 5'h12;
  localparam logic [4:0] KEY_EXE = 5'h13;
  localparam logic [4:0] KEY_SUB = 5'h14;
  localparam logic [4:0] KEY_OR  = 5'h15;
  localparam logic [4:0] KEY_CE  = 5'h16;
  localparam logic [4:0] KEY_CLR = 5'h17;

  typedef enum logic [2:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    MUL = 3'd2,
    AND = 3'd3,
    OR  = 3'd4
  } alu_op_t;

  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    EXEC    = 2'd2,
    SHOW    = 2'd3
  } state_t;

  function automatic logic is_op_key(input logic [4:0] key);
    return (key == KEY_ADD) || (key == KEY_MUL) || (key == KEY_AND) ||
           (key == KEY_SUB) || (key == KEY_OR);
  endfunction

  function automatic alu_op_t key_to_op(input logic [4:0] key);
    alu_op_t op;
    case (key)
      KEY_SUB: op = SUB;
      KEY_MUL: op = MUL;
      KEY_AND: op = AND;
      KEY_OR:  op = OR;
      default: op = ADD;
    endcase
    return op;
  endfunction

endpackage

`default_nettype wire

// File: rtl/calc_operand_reg.sv
//------------------------------------------------------------------------------
// calc_operand_reg : digit shift accumulator with digit count, decimal filter
//                    and clear. Clear has priority over load and shift.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module calc_operand_reg #(
  parameter int DIGITS = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic                         shift,
  input  logic                         load,
  input  logic [3:0]                   digit,
  input  logic                         dec_mode,
  output logic                         digit_ok,
  output logic [4*DIGITS-1:0]          acc,
  output logic [$clog2(DIGITS+1)-1:0]  cnt
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);

  logic [W-1:0]  r_acc;
  logic [CW-1:0] r_cnt;

  assign digit_ok = !(dec_mode && (digit >= 4'd10));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (clr) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (load && digit_ok) begin
      r_acc <= W'(digit);
      r_cnt <= CW'(1);
    end else if (shift && digit_ok && (r_cnt != CW'(DIGITS))) begin
      r_acc <= (r_acc << 4) | W'(digit);
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign acc = r_acc;
  assign cnt = r_cnt;

endmodule

`default_nettype wire

// File: rtl/calc_entry_ctrl.sv
//------------------------------------------------------------------------------
// calc_entry_ctrl : key sequencer between keypad cursor and calculator ALU.
//                   Optional ALU acknowledge timeout: CALC_ALU_TIMEOUT_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module calc_entry_ctrl
  import calc_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 select,
  input  logic [4:0]           val,
  input  logic                 dec_mode,
  output logic                 restriction,
  output logic                 alu_req,
  output logic [2:0]           alu_op,
  output logic [4*DIGITS-1:0]  op_a,
  output logic [4*DIGITS-1:0]  op_b,
  input  logic                 alu_ack,
  input  logic [4*DIGITS-1:0]  alu_result,
  output logic [4*DIGITS-1:0]  display,
  output logic                 busy,
  output logic                 err
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t        r_state, w_state_nxt;
  alu_op_t       r_op, w_op_nxt;
  logic [W-1:0]  r_op_a, w_op_a_nxt;
  logic [W-1:0]  r_op_b, w_op_b_nxt;
  logic [W-1:0]  r_res, w_res_nxt;
  logic          r_clr_pend, w_clr_pend_nxt;
  logic          w_acc_clr, w_acc_shift, w_acc_load, w_full_clr;
  logic          w_digit_ok;
  logic [W-1:0]  w_acc;
  logic [CW-1:0] w_cnt;
  logic          w_is_digit, w_is_op;

`ifdef CALC_ALU_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_tmo, w_tmo_nxt;
  logic          r_err, w_err_nxt, w_tmo_hit;
`endif

  assign w_is_digit = !val[4];
  assign w_is_op    = is_op_key(val);

  calc_operand_reg #(.DIGITS(DIGITS)) u_operand (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (w_acc_clr),
    .shift    (w_acc_shift),
    .load     (w_acc_load),
    .digit    (val[3:0]),
    .dec_mode (dec_mode),
    .digit_ok (w_digit_ok),
    .acc      (w_acc),
    .cnt      (w_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ENTER_A;
      r_op       <= ADD;
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_res      <= '0;
      r_clr_pend <= 1'b0;
`ifdef CALC_ALU_TIMEOUT_EN
      r_tmo      <= '0;
      r_err      <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_op       <= w_op_nxt;
      r_op_a     <= w_op_a_nxt;
      r_op_b     <= w_op_b_nxt;
      r_res      <= w_res_nxt;
      r_clr_pend <= w_clr_pend_nxt;
`ifdef CALC_ALU_TIMEOUT_EN
      r_tmo      <= w_tmo_nxt;
      r_err      <= w_err_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_op_nxt       = r_op;
    w_op_a_nxt     = r_op_a;
    w_op_b_nxt     = r_op_b;
    w_res_nxt      = r_res;
    w_clr_pend_nxt = r_clr_pend;
    w_acc_clr      = 1'b0;
    w_acc_shift    = 1'b0;
    w_acc_load     = 1'b0;
    w_full_clr     = 1'b0;
`ifdef CALC_ALU_TIMEOUT_EN
    w_tmo_nxt      = '0;
    w_err_nxt      = r_err;
    w_tmo_hit      = 1'b0;
`endif

    case (r_state)
      ENTER_A, ENTER_B: begin
        if (select) begin
          if (w_is_digit) begin
            w_acc_shift = 1'b1;
          end else if (w_is_op) begin
            if (r_state == ENTER_A) begin
              w_op_a_nxt  = w_acc;
              w_op_nxt    = key_to_op(val);
              w_acc_clr   = 1'b1;
              w_state_nxt = ENTER_B;
            end else if (w_cnt == '0) begin
              w_op_nxt = key_to_op(val);
            end
          end else if (val == KEY_EXE) begin
            if ((r_state == ENTER_B) && (w_cnt != '0)) begin
              w_op_b_nxt  = w_acc;
              w_acc_clr   = 1'b1;
              w_state_nxt = EXEC;
            end
          end else if (val == KEY_CE) begin
            w_acc_clr = 1'b1;
          end else if (val == KEY_CLR) begin
            w_full_clr = 1'b1;
          end
        end
      end

      EXEC: begin
        // A key arriving with the acknowledge is dropped; the ack wins.
        if (alu_ack) begin
          if (r_clr_pend) begin
            w_full_clr = 1'b1;
          end else begin
            w_res_nxt   = alu_result;
            w_state_nxt = SHOW;
          end
        end else begin
          if (select && (val == KEY_CLR)) begin
            w_clr_pend_nxt = 1'b1;
          end
`ifdef CALC_ALU_TIMEOUT_EN
          if (r_tmo == TW'(TIMEOUT_CYCLES - 1)) begin
            w_tmo_hit  = 1'b1;
            w_full_clr = 1'b1;
          end else begin
            w_tmo_nxt = r_tmo + TW'(1);
          end
`endif
        end
      end

      SHOW: begin
        if (select) begin
          // Decimal filter also guards the digit that starts a new entry.
          if (w_is_digit) begin
            if (w_digit_ok) begin
              w_acc_load  = 1'b1;
              w_state_nxt = ENTER_A;
            end
          end else if (w_is_op) begin
            w_op_a_nxt  = r_res;
            w_op_nxt    = key_to_op(val);
            w_acc_clr   = 1'b1;
            w_state_nxt = ENTER_B;
          end else if ((val == KEY_CE) || (val == KEY_CLR)) begin
            w_full_clr = 1'b1;
          end
        end
      end

      default: w_full_clr = 1'b1;
    endcase

    if (w_full_clr) begin
      w_state_nxt    = ENTER_A;
      w_op_nxt       = ADD;
      w_op_a_nxt     = '0;
      w_op_b_nxt     = '0;
      w_res_nxt      = '0;
      w_clr_pend_nxt = 1'b0;
      w_acc_clr      = 1'b1;
      w_acc_load     = 1'b0;
      w_acc_shift    = 1'b0;
`ifdef CALC_ALU_TIMEOUT_EN
      w_err_nxt      = w_tmo_hit;
`endif
    end
  end

  always_comb begin
    display = w_acc;
    case (r_state)
      EXEC:    display = r_op_b;
      SHOW:    display = r_res;
      default: display = w_acc;
    endcase
  end

  assign restriction = dec_mode;
  assign alu_req     = (r_state == EXEC);
  assign busy        = (r_state == EXEC);
  assign alu_op      = r_op;
  assign op_a        = r_op_a;
  assign op_b        = r_op_b;

`ifdef CALC_ALU_TIMEOUT_EN
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_calc_entry_ctrl.sv
//------------------------------------------------------------------------------
// tb_calc_entry_ctrl : directed scenarios plus randomized key/ack traffic
//                      against a queue-based behavioural model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_calc_entry_ctrl;

  localparam int W   = 16;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          select = 1'b0;
  logic [4:0]    val = 5'd0;
  logic          dec_mode = 1'b0;
  logic          alu_ack = 1'b0;
  logic [W-1:0]  alu_result = '0;
  logic          restriction, alu_req, busy, err;
  logic [2:0]    alu_op;
  logic [W-1:0]  op_a, op_b, display;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  calc_entry_ctrl #(.DIGITS(4), .TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .select      (select),
    .val         (val),
    .dec_mode    (dec_mode),
    .restriction (restriction),
    .alu_req     (alu_req),
    .alu_op      (alu_op),
    .op_a        (op_a),
    .op_b        (op_b),
    .alu_ack     (alu_ack),
    .alu_result  (alu_result),
    .display     (display),
    .busy        (busy),
    .err         (err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [4:0] k);
    select = 1'b1;
    val    = k;
    tick();
    select = 1'b0;
    val    = 5'd0;
  endtask

  task automatic ack_with(input logic [W-1:0] r);
    alu_result = r;
    alu_ack    = 1'b1;
    tick();
    alu_ack    = 1'b0;
  endtask

  // ---------------- behavioural model ----------------
  int m_phase;       // 0 first operand, 1 second operand, 2 waiting on ALU, 3 result shown
  int m_q[$];
  int m_op_a, m_op_b, m_res, m_op, m_wait;
  bit m_pend, m_err;

  function automatic int m_value();
    int v = 0;
    foreach (m_q[i]) v = v * 16 + m_q[i];
    return v;
  endfunction

  function automatic int m_opcode(input int k);
    case (k)
      16: return 0;
      20: return 1;
      17: return 2;
      18: return 3;
      default: return 4;
    endcase
  endfunction

  function automatic bit m_is_op(input int k);
    return (k == 16) || (k == 17) || (k == 18) || (k == 20) || (k == 21);
  endfunction

  task automatic model_clear();
    m_phase = 0; m_q.delete(); m_op_a = 0; m_op_b = 0; m_res = 0;
    m_op = 0; m_pend = 0; m_err = 0; m_wait = 0;
  endtask

  task automatic model_step(input bit sel, input int k, input bit dec, input bit ack, input int result);
    bit ok = !(dec && k >= 10);
    case (m_phase)
      0, 1: if (sel) begin
        if (k < 16) begin
          if (ok && m_q.size() < 4) m_q.push_back(k);
        end else if (m_is_op(k)) begin
          if (m_phase == 0) begin
            m_op_a = m_value(); m_op = m_opcode(k); m_q.delete(); m_phase = 1;
          end else if (m_q.size() == 0) m_op = m_opcode(k);
        end else if (k == 19) begin
          if (m_phase == 1 && m_q.size() > 0) begin
            m_op_b = m_value(); m_q.delete(); m_phase = 2; m_wait = 0;
          end
        end else if (k == 22) m_q.delete();
        else if (k == 23) model_clear();
      end
      2: begin
        if (ack) begin
          if (m_pend) model_clear();
          else begin m_res = result; m_phase = 3; end
        end else begin
          if (sel && k == 23) m_pend = 1;
`ifdef CALC_ALU_TIMEOUT_EN
          m_wait++;
          if (m_wait == TMO) begin model_clear(); m_err = 1; end
`endif
        end
      end
      default: if (sel) begin
        if (k < 16) begin
          if (ok) begin m_q.delete(); m_q.push_back(k); m_phase = 0; end
        end else if (m_is_op(k)) begin
          m_op_a = m_res; m_op = m_opcode(k); m_q.delete(); m_phase = 1;
        end else if (k == 22 || k == 23) model_clear();
      end
    endcase
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if ({alu_req, busy, err, restriction, alu_op} !== 7'd0 || op_a !== '0 || op_b !== '0 || display !== '0) begin
      failures++;
      $display("FAIL reset_outputs: req=%0b busy=%0b err=%0b restr=%0b op=%0d a=%h b=%h disp=%h, required all 0",
               alu_req, busy, err, restriction, alu_op, op_a, op_b, display);
    end
    dec_mode = 1'b1;
    #1;
    checks++;
    if (restriction !== 1'b1) begin
      failures++; $display("FAIL reset_restriction: got %b, required 1", restriction);
    end
    dec_mode = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_hex_add();
    press(5'h01); press(5'h02);
    checks++;
    if (display !== 16'h0012) begin failures++; $display("FAIL hex_entry_display: got %h, required 0012", display); end
    press(5'h10); press(5'h03);
    checks++;
    if (alu_req !== 1'b0 || display !== 16'h0003) begin
      failures++; $display("FAIL hex_before_exe: req=%b disp=%h, required req=0 disp=0003", alu_req, display);
    end
    press(5'h13);
    checks++;
    if (alu_req !== 1'b1 || busy !== 1'b1) begin
      failures++; $display("FAIL hex_req_rise: req=%b busy=%b, required 1/1", alu_req, busy);
    end
    checks++;
    if (op_a !== 16'h0012 || op_b !== 16'h0003 || alu_op !== 3'd0) begin
      failures++; $display("FAIL hex_operands: a=%h b=%h op=%0d, required 0012 0003 0", op_a, op_b, alu_op);
    end
    ack_with(16'h0015);
    checks++;
    if (alu_req !== 1'b0 || display !== 16'h0015 || busy !== 1'b0) begin
      failures++; $display("FAIL hex_result: req=%b busy=%b disp=%h, required 0 0 0015", alu_req, busy, display);
    end
  endtask

  task automatic test_chain_sub();
    press(5'h14); press(5'h05); press(5'h13);
    checks++;
    if (alu_req !== 1'b1 || op_a !== 16'h0015 || op_b !== 16'h0005 || alu_op !== 3'd1) begin
      failures++; $display("FAIL chain_sub: req=%b a=%h b=%h op=%0d, required 1 0015 0005 1", alu_req, op_a, op_b, alu_op);
    end
    ack_with(16'h0010);
    checks++;
    if (display !== 16'h0010) begin failures++; $display("FAIL chain_result: got %h, required 0010", display); end
  endtask

  task automatic test_decimal();
    press(5'h17);
    checks++;
    if (display !== '0 || op_a !== '0) begin failures++; $display("FAIL clr_from_show: disp=%h a=%h, required 0 0", display, op_a); end
    dec_mode = 1'b1;
    #1;
    checks++;
    if (restriction !== 1'b1) begin failures++; $display("FAIL dec_restriction: got %b, required 1", restriction); end
    press(5'h0A);
    for (int i = 0; i < 5; i++) press(5'h09);
    checks++;
    if (display !== 16'h9999) begin failures++; $display("FAIL dec_filter_full: got %h, required 9999", display); end
    press(5'h12);
    checks++;
    if (op_a !== 16'h9999 || alu_op !== 3'd3 || display !== '0) begin
      failures++; $display("FAIL dec_operator: a=%h op=%0d disp=%h, required 9999 3 0000", op_a, alu_op, display);
    end
    press(5'h17);
    dec_mode = 1'b0;
  endtask

  task automatic test_clr_in_exec();
    int bad = 0;
    press(5'h01); press(5'h10); press(5'h02); press(5'h13);
    press(5'h17);
    for (int i = 0; i < 10; i++) begin
      if (alu_req !== 1'b1) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL clr_exec_req_hold: req low in %0d cycles, required 0", bad); end
    ack_with(16'h0077);
    checks++;
    if (alu_req !== 1'b0 || busy !== 1'b0 || display !== '0 || op_a !== '0 || op_b !== '0) begin
      failures++; $display("FAIL clr_exec_after_ack: req=%b busy=%b disp=%h a=%h b=%h, required all 0",
                           alu_req, busy, display, op_a, op_b);
    end
    press(5'h05); press(5'h11);
    checks++;
    if (op_a !== 16'h0005 || alu_op !== 3'd2) begin
      failures++; $display("FAIL clr_exec_restart: a=%h op=%0d, required 0005 2", op_a, alu_op);
    end
    press(5'h17);
  endtask

  task automatic test_async_reset();
    press(5'h03); press(5'h10); press(5'h04); press(5'h13);
    checks++;
    if (alu_req !== 1'b1) begin failures++; $display("FAIL areset_setup: req=%b, required 1", alu_req); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (alu_req !== 1'b0 || busy !== 1'b0 || op_a !== '0 || op_b !== '0 || display !== '0 || alu_op !== 3'd0) begin
      failures++; $display("FAIL areset_mid_exec: req=%b busy=%b a=%h b=%h disp=%h op=%0d, required all 0",
                           alu_req, busy, op_a, op_b, display, alu_op);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_timeout();
    int n = 0;
    press(5'h01); press(5'h10); press(5'h02); press(5'h13);
`ifdef CALC_ALU_TIMEOUT_EN
    while (alu_req === 1'b1 && n < 40) begin n++; tick(); end
    checks++;
    if (n != TMO) begin failures++; $display("FAIL timeout_req_cycles: got %0d, required %0d", n, TMO); end
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || display !== '0) begin
      failures++; $display("FAIL timeout_err: err=%b busy=%b disp=%h, required 1 0 0000", err, busy, display);
    end
    press(5'h17);
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL timeout_err_clear: got %b, required 0", err); end
`else
    while (alu_req === 1'b1 && n < 40) begin n++; tick(); end
    checks++;
    if (n != 40 || err !== 1'b0) begin
      failures++; $display("FAIL no_timeout_wait: req held %0d cycles err=%b, required 40 and 0", n, err);
    end
    ack_with(16'h0003);
    press(5'h17);
`endif
  endtask

  task automatic test_random();
    int r, k;
    bit s, a;
    int res;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    dec_mode = 1'b0;
    model_clear();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if ($urandom_range(0, 19) == 0) dec_mode = ~dec_mode;
      s = ($urandom_range(0, 2) != 0);
      r = $urandom_range(0, 99);
      if (r < 50)      k = $urandom_range(0, 15);
      else if (r < 70) begin
        case ($urandom_range(0, 4))
          0: k = 16; 1: k = 17; 2: k = 18; 3: k = 20; default: k = 21;
        endcase
      end
      else if (r < 85) k = 19;
      else if (r < 89) k = 22;
      else if (r < 92) k = 23;
      else             k = $urandom_range(24, 31);
      a   = (m_phase == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 29) == 0);
      res = int'($urandom_range(0, 65535));
      select = s; val = 5'(k); alu_ack = a; alu_result = W'(res);
      model_step(s, k, dec_mode, a, res);
      tick();
      select = 1'b0; alu_ack = 1'b0;
      checks++;
      if (display !== W'(m_phase < 2 ? m_value() : (m_phase == 2 ? m_op_b : m_res))) begin
        failures++; $display("FAIL rnd_display cyc=%0d: got %h, required %h", cyc, display,
                             W'(m_phase < 2 ? m_value() : (m_phase == 2 ? m_op_b : m_res)));
      end
      checks++;
      if (alu_req !== (m_phase == 2) || busy !== (m_phase == 2)) begin
        failures++; $display("FAIL rnd_req cyc=%0d: req=%b busy=%b, required %0b", cyc, alu_req, busy, m_phase == 2);
      end
      checks++;
      if (op_a !== W'(m_op_a) || op_b !== W'(m_op_b) || alu_op !== 3'(m_op)) begin
        failures++; $display("FAIL rnd_operands cyc=%0d: a=%h b=%h op=%0d, required %h %h %0d",
                             cyc, op_a, op_b, alu_op, W'(m_op_a), W'(m_op_b), m_op);
      end
      checks++;
      if (err !== m_err || restriction !== dec_mode) begin
        failures++; $display("FAIL rnd_flags cyc=%0d: err=%b restr=%b, required %b %b", cyc, err, restriction, m_err, dec_mode);
      end
    end
  endtask

  initial begin
    test_reset();
    test_hex_add();
    test_chain_sub();
    test_decimal();
    test_clr_in_exec();
    test_async_reset();
    test_timeout();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/calc_entry_ctrl.md
# calc_entry_ctrl

Sequencer between the keypad grid cursor and the calculator ALU. Decodes the cursor's 5-bit key code on each select press, builds two hex/decimal operands digit by digit, latches the operator, and on EXE issues one request/acknowledge transaction to the ALU. Drives the cursor's `restriction` input, which blocks digits A–F in decimal mode, and provides the value shown on the display.

## Interface
- `DIGITS`, default 4: maximum digits per operand; operand width W = 4·DIGITS.
- `TIMEOUT_CYCLES`, default 1024: ALU acknowledge timeout. Used only when `CALC_ALU_TIMEOUT_EN` is defined.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `select`  in  1  one-cycle pulse; key confirmed (already debounced).
- `val`  in  5  cursor key code, sampled when `select`=1.
- `dec_mode`  in  1  1 = decimal entry, 0 = hex entry.
- `restriction`  out  1  equals `dec_mode`; sent to the cursor.
- `alu_req`  out  1  ALU request.
- `alu_op`  out  3  operator code.
- `op_a`, `op_b`  out  W  operands.
- `alu_ack`  in  1  ALU done; `alu_result` is valid in the same cycle.
- `alu_result`  in  W  ALU result.
- `display`  out  W  value to show.
- `busy`  out  1  state is EXEC.
- `err`  out  1  sticky timeout flag. Held at 0 when the timeout feature is compiled out.

## Operation
- Key codes:
  - 0x00–0x0F: digit.
  - 0x10 ADD, 0x11 MUL, 0x12 AND, 0x13 EXE, 0x14 SUB, 0x15 OR, 0x16 CE, 0x17 CLR.
  - Any other code is ignored.
- States: ENTER_A, ENTER_B, EXEC, SHOW. Reset state is ENTER_A.
- Reset values: all registers and outputs 0, except `restriction`, which follows `dec_mode`.
- Digit in ENTER_A or ENTER_B:
  - acc ← {acc[W-5:0], d}; cnt++.
  - Ignored if cnt = DIGITS.
  - Ignored if `dec_mode`=1 and d ≥ 10.
- Operator in ENTER_A:
  - op_a ← acc (0 if nothing was entered); latch op.
  - Clear acc and cnt; go to ENTER_B.
- Operator in ENTER_B:
  - If cnt = 0: replace the latched op.
  - Otherwise: ignored.
- EXE:
  - In ENTER_B with cnt > 0: op_b ← acc; go to EXEC.
  - Anywhere else: ignored.
- EXEC:
  - `alu_req`=1. `op_a`, `op_b`, `alu_op` stay stable until `alu_ack`.
  - On `alu_ack`: res ← `alu_result`; go to SHOW.
  - All keys are ignored except CLR.
- SHOW:
  - Digit: acc ← d, cnt = 1; go to ENTER_A.
  - Operator: op_a ← res; latch op; go to ENTER_B (chained operation).
  - CE: same as CLR.
- CE in ENTER_A or ENTER_B: clears acc and cnt only.
- CLR:
  - In any non-EXEC state: return to the reset state.
  - In EXEC: set `clr_pend`. Keep `alu_req` high until `alu_ack`, then discard the result and go to the reset state.
- `display`:
  - Shows acc in ENTER_A and ENTER_B.
  - Shows op_b in EXEC.
  - Shows res in SHOW.
- A change of `dec_mode` mid-entry does not alter acc. The digit filter applies only to later key presses.

## Timing
- A `select` press at edge N produces the state and acc update visible after edge N.
- EXE at edge N: `alu_req`=1 from N+1.
- `alu_ack` sampled high at edge M:
  - res and `display` are updated after M.
  - `alu_req`=0 after M.
  - The ALU must drop `alu_ack` after it sees `alu_req`=0.
- `alu_ack` while `alu_req`=0 is ignored.
- `select` in the same cycle as `alu_ack` is ignored; no key is lost outside EXEC.
- `rst_n` low at any time, including mid-EXEC:
  - Immediately clears all state; `alu_req` drops asynchronously.
  - The ALU must tolerate the abandoned request.

## Configuration
- `CALC_ALU_TIMEOUT_EN` defined:
  - A counter runs in EXEC.
  - If the count reaches `TIMEOUT_CYCLES` without `alu_ack`: drop `alu_req`, set `err`=1, go to ENTER_A cleared.
  - `err` is cleared by CLR or reset.
- Not defined: no counter; EXEC waits indefinitely; `err` is tied to 0.

## Structure
- Package `calc_pkg` holds:
  - key-code localparams (KEY_ADD … KEY_CLR);
  - `alu_op_t` enum: ADD=0, SUB=1, MUL=2, AND=3, OR=4;
  - `state_t` enum.
- Key-to-`alu_op` mapping function lives in the package.
- One sub-module, `calc_operand_reg`: digit shift accumulator with count, digit filter and clear. The FSM and handshake stay in the top module.

## Test plan
- Hex mode, keys 1, 2, ADD, 3, EXE, ACK with result 0x15:
  - `alu_req` goes high one cycle after EXE with op_a=0x12, op_b=0x3, alu_op=0.
  - After ACK, `display`=0x15.
- Decimal mode, keys A, 9, 9, 9, 9, 9:
  - acc=0x9999 and cnt=4; the A and the fifth 9 are ignored.
  - `restriction`=1.
- After SHOW with result 0x15, keys SUB, 5, EXE:
  - op_a=0x15, op_b=0x5, alu_op=1.
- Key CLR during EXEC with ACK delayed 10 cycles:
  - `alu_req` stays high until ACK.
  - Then state is ENTER_A, `display`=0, and the result is discarded.
- `rst_n` pulsed low mid-EXEC: `alu_req`=0 immediately; all outputs 0.
- With `CALC_ALU_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8, no ACK after EXE:
  - `alu_req` falls after 8 cycles and `err`=1.
  - Key CLR clears `err`.
